// File: rtl/lvds_tx_arbiter.sv
// lvds_tx_arbiter: round-robin, burst-limited sharing of the 32-bit LVDS transmit word channel
module lvds_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PAYLOAD_W = 29,
    parameter int MAX_BURST = 4
) (
    input  logic                           tx_inclock,
    input  logic                           reset_n,
    input  logic                           link_up,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_rdy,
    output logic [NUM_REQ-1:0]             req_en,
    output logic [31:0]                    enq_tx,
    output logic                           RDY_enq_tx,
    input  logic                           EN_enq_tx,
    output logic [1:0]                     cur_src,
    output logic [3:0]                     burst_cnt
);
    logic [31:0] enq_tx_q, enq_tx_d;
    logic        rdy_q, rdy_d;
    logic [1:0]  cur_src_q, cur_src_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        go, cont;
    logic [1:0]  rr, idx, winner;
    always_comb begin
        rr  = cur_src_q;
        idx = cur_src_q;
        // scan from farthest to nearest so the nearest ready requester after cur_src wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 2'((int'(cur_src_q) + k) % NUM_REQ);
            rr  = req_rdy[idx] ? idx : rr;
        end
        go          = reset_n && (!rdy_q || EN_enq_tx) && link_up && (|req_rdy);
        cont        = req_rdy[cur_src_q] && burst_cnt_q != 4'd0 && burst_cnt_q < 4'(MAX_BURST);
        winner      = cont ? cur_src_q : rr;
        req_en      = go ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;
        enq_tx_d    = go ? {1'b1, winner, req_data[int'(winner)*PAYLOAD_W +: PAYLOAD_W]} : enq_tx_q;
        rdy_d       = go || (rdy_q && !EN_enq_tx);
        cur_src_d   = go ? winner : cur_src_q;
        burst_cnt_d = go ? (cont ? burst_cnt_q + 4'd1 : 4'd1) : burst_cnt_q;
    end
    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            enq_tx_q    <= '0;
            rdy_q       <= 1'b0;
            cur_src_q   <= 2'(NUM_REQ-1);
            burst_cnt_q <= '0;
        end else begin
            enq_tx_q    <= enq_tx_d;
            rdy_q       <= rdy_d;
            cur_src_q   <= cur_src_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
    assign enq_tx     = enq_tx_q;
    assign RDY_enq_tx = rdy_q;
    assign cur_src    = cur_src_q;
    assign burst_cnt  = burst_cnt_q;
endmodule
